branch_redirect_ctl: RTL and testbench
======================================

BRANCH_REDIRECT_CTL -- requirements
Module: branch_redirect_ctl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous reset, active-low (0 = reset).
REQ-003 SHALL have: ex_valid  in  1  EX stage holds a valid instruction this cycle.
REQ-004 SHALL have: ex_op  in  5  EX opcode; conditional branch when ex_op[4:2] == 3'b011 (01100..01111).
REQ-005 SHALL have: ex_branchEN  in  1  branch-condition result for the EX instruction (1 = taken).
REQ-006 SHALL have: ex_pc_plus2  in  16  PC+2 of the EX instruction.
REQ-007 SHALL have: ex_imm8  in  8  branch displacement, two's complement.
REQ-008 SHALL have: redirect_ready  in  1  fetch accepts redirect this cycle.
REQ-009 SHALL have: redirect_valid  out  1  redirect request to fetch.
REQ-010 SHALL have: redirect_pc  out  16  new fetch PC.
REQ-011 SHALL have: flush_ifid  out  1  squash IF/ID register.
REQ-012 SHALL have: flush_idex  out  1  squash ID/EX register.
REQ-013 SHALL have: br_cnt  out  16  resolved-branch count.
REQ-014 SHALL have: taken_cnt  out  16  taken-branch count.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE, REDIR, FLUSH; all outputs registered or decoded from state/registers only.
REQ-016 Branch event SHALL be: state==IDLE & ex_valid & ex_op[4:2]==3'b011; taken event = branch event & ex_branchEN.
REQ-017 IDLE: on taken event -> REDIR next edge, latching target = ex_pc_plus2 + sign_extend(ex_imm8) into redirect_pc; otherwise stay IDLE.
REQ-018 Target arithmetic SHALL be 16-bit modulo (wrap, no overflow flag); e.g. 16'hFFFE + 8'h04 -> 16'h0002, 16'h0002 + 8'hFC -> 16'hFFFE.
REQ-019 REDIR: redirect_valid=1, flush_ifid=1, flush_idex=1 every cycle; redirect_pc held stable until accepted.
REQ-020 REDIR: redirect_ready=1 -> FLUSH next edge; redirect_ready=0 -> stay REDIR (no timeout).
REQ-021 FLUSH: redirect_valid=0, flush_ifid=1, flush_idex=0 for exactly one cycle, then IDLE.
REQ-022 IDLE: redirect_valid, flush_ifid, flush_idex SHALL all be 0.
REQ-023 Branch/taken inputs SHALL be ignored in REDIR and FLUSH (EX content is squashed); no counting, no re-latch.
REQ-024 br_cnt SHALL increment by 1 on each branch event; taken_cnt on each taken event; both saturate at 16'hFFFF.
REQ-025 Latency: taken event at edge N -> redirect_valid=1 after edge N+1; minimum taken-to-IDLE = 3 cycles with redirect_ready held 1.
REQ-026 Not-taken branch SHALL cause no redirect/flush, only br_cnt increment.
REQ-027 redirect_pc SHALL retain its last latched value in IDLE and FLUSH.

Reset
REQ-028 rst=0 SHALL immediately (no clock) force state=IDLE, redirect_valid=0, flush_ifid=0, flush_idex=0, redirect_pc=16'h0000, br_cnt=0, taken_cnt=0.
REQ-029 Reset asserted in REDIR or FLUSH SHALL abort the redirect; no pending request survives reset deassertion.
REQ-030 First branch event SHALL be recognised on the first rising edge with rst=1.

Verification
REQ-031 Taken: ex_valid=1, ex_op=5'b01100, ex_branchEN=1, ex_pc_plus2=16'h0010, ex_imm8=8'h06, redirect_ready=1 -> redirect_valid=1 with redirect_pc=16'h0016 and both flushes for one cycle, then flush_ifid-only cycle, then IDLE; br_cnt=1, taken_cnt=1.
REQ-032 Not-taken: ex_op=5'b01111, ex_branchEN=0 -> all redirect/flush outputs 0; br_cnt=1, taken_cnt=0.
REQ-033 Backpressure: taken with target 16'h0020, redirect_ready=0 for 4 cycles then 1 -> redirect_valid and pc=16'h0020 stable 5 cycles, FLUSH once; a taken branch presented during REDIR is not counted.
REQ-034 Wrap/negative: ex_pc_plus2=16'h0002, ex_imm8=8'hFC -> redirect_pc=16'hFFFE; ex_pc_plus2=16'hFFFE, ex_imm8=8'h04 -> 16'h0002.
REQ-035 Reset mid-op: rst=0 while in REDIR -> outputs 0 and counters 0 without clock edge; after rst=1 no redirect until a new taken event.
REQ-036 Saturation: preload via 65535 branch events, one more taken event -> br_cnt stays 16'hFFFF, taken_cnt increments normally.

Source files
------------

// File: rtl/branch_redirect_ctl.sv
// branch_redirect_ctl: turns a taken EX-stage branch into a held fetch redirect plus IF/ID and ID/EX flushes, and counts branches
module branch_redirect_ctl (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [4:0]  ex_op,
   input  logic        ex_branchEN,
   input  logic [15:0] ex_pc_plus2,
   input  logic [7:0]  ex_imm8,
   input  logic        redirect_ready,
   output logic        redirect_valid,
   output logic [15:0] redirect_pc,
   output logic        flush_ifid,
   output logic        flush_idex,
   output logic [15:0] br_cnt,
   output logic [15:0] taken_cnt
);
   typedef enum logic [1:0] {IDLE, REDIR, FLUSH} state_e;
   state_e      state_q, state_d;
   logic        br_ev, tk_ev;
   logic [15:0] pc_q, pc_d, br_q, br_d, tk_q, tk_d;
   logic        rv_q, rv_d, fi_q, fi_d, fx_q, fx_d;
   // EX content is squashed while a redirect is in flight, so events only exist in IDLE
   assign br_ev = (state_q == IDLE) && ex_valid && (ex_op inside {[5'b01100:5'b01111]});
   assign tk_ev = br_ev && ex_branchEN;
   always_comb begin
      state_d = state_q == IDLE  ? (tk_ev ? REDIR : IDLE) :
                state_q == REDIR ? (redirect_ready ? FLUSH : REDIR) : IDLE;
      pc_d    = tk_ev ? ex_pc_plus2 + {{8{ex_imm8[7]}}, ex_imm8} : pc_q;
      br_d    = (br_ev && br_q != 16'hFFFF) ? br_q + 16'd1 : br_q;
      tk_d    = (tk_ev && tk_q != 16'hFFFF) ? tk_q + 16'd1 : tk_q;
      rv_d    = state_d == REDIR;
      fi_d    = state_d != IDLE;
      fx_d    = state_d == REDIR;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pc_q    <= '0;
         br_q    <= '0;
         tk_q    <= '0;
         rv_q    <= 1'b0;
         fi_q    <= 1'b0;
         fx_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         br_q    <= br_d;
         tk_q    <= tk_d;
         rv_q    <= rv_d;
         fi_q    <= fi_d;
         fx_q    <= fx_d;
      end
   end
   assign redirect_valid = rv_q;
   assign redirect_pc    = pc_q;
   assign flush_ifid     = fi_q;
   assign flush_idex     = fx_q;
   assign br_cnt         = br_q;
   assign taken_cnt      = tk_q;
endmodule

// File: tb/tb_branch_redirect_ctl.sv
// tb_branch_redirect_ctl: random and directed stimulus with a transaction-level model; a negedge monitor checks DUT outputs against the queued redirects
module tb_branch_redirect_ctl;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ex_valid = 1'b0;
   logic [4:0]  ex_op = '0;
   logic        ex_branchEN = 1'b0;
   logic [15:0] ex_pc_plus2 = '0;
   logic [7:0]  ex_imm8 = '0;
   logic        redirect_ready = 1'b0;
   logic        redirect_valid, flush_ifid, flush_idex;
   logic [15:0] redirect_pc, br_cnt, taken_cnt;

   int          errs = 0;
   int          checks = 0;
   logic [15:0] exp_q[$];
   int          br_m = 0;
   int          tk_m = 0;
   logic [15:0] last_pc_m = '0;
   bit          waiting = 0;
   bit          flushing = 0;
   bit          exp_flush = 0;

   branch_redirect_ctl dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op), .ex_branchEN(ex_branchEN),
      .ex_pc_plus2(ex_pc_plus2), .ex_imm8(ex_imm8), .redirect_ready(redirect_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush_ifid(flush_ifid),
      .flush_idex(flush_idex), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errs++;
         $display("FAIL %s: got %0h need %0h at %0t", name, act, req, $time);
      end
   endtask

   // drive one cycle of inputs, then advance the model by what the DUT saw at the edge
   task automatic cyc(input logic v, input logic [4:0] op, input logic en,
                      input logic [15:0] pc, input logic [7:0] imm, input logic rdy);
      logic [15:0] t;
      ex_valid = v; ex_op = op; ex_branchEN = en; ex_pc_plus2 = pc; ex_imm8 = imm; redirect_ready = rdy;
      @(posedge clk);
      if (rst) begin
         if (!waiting && !flushing) begin
            if (v && op >= 5'd12 && op <= 5'd15) begin
               br_m = br_m < 65535 ? br_m + 1 : 65535;
               if (en) begin
                  tk_m = tk_m < 65535 ? tk_m + 1 : 65535;
                  t = 16'((int'(pc) + int'($signed(imm))) & 32'hFFFF);
                  exp_q.push_back(t);
                  last_pc_m = t;
                  waiting = 1;
               end
            end
         end else if (waiting) begin
            if (rdy) begin
               waiting = 0;
               flushing = 1;
            end
         end else flushing = 0;
      end
      #1;
   endtask

   task automatic idle(input logic rdy, input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 5'b00000, 1'b0, 16'h0, 8'h0, rdy);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         exp_flush = 0;
         chk("rst_outputs", {redirect_valid, flush_ifid, flush_idex}, 0);
         chk("rst_pc", redirect_pc, 0);
      end else if (redirect_valid) begin
         chk("redirect_outstanding", int'(exp_q.size() > 0), 1);
         chk("redir_flushes", {flush_ifid, flush_idex}, 3);
         if (exp_q.size() > 0) begin
            chk("redirect_pc", redirect_pc, exp_q[0]);
            if (redirect_ready) begin
               void'(exp_q.pop_front());
               exp_flush = 1;
            end
         end
      end else if (exp_flush) begin
         chk("flush_cycle", {flush_ifid, flush_idex}, 2);
         chk("flush_pc", redirect_pc, last_pc_m);
         exp_flush = 0;
      end else begin
         chk("idle_flushes", {flush_ifid, flush_idex}, 0);
         chk("missing_redirect", exp_q.size(), 0);
         chk("held_pc", redirect_pc, last_pc_m);
      end
      chk("br_cnt", br_cnt, br_m);
      chk("taken_cnt", taken_cnt, tk_m);
   end

   initial begin
      @(posedge clk); #1;
      idle(1'b1, 1);
      rst = 1'b1;
      // taken, immediate accept
      cyc(1'b1, 5'b01100, 1'b1, 16'h0010, 8'h06, 1'b1);
      idle(1'b1, 3);
      // not-taken
      cyc(1'b1, 5'b01111, 1'b0, 16'h0040, 8'h10, 1'b1);
      idle(1'b1, 2);
      // backpressure with a second taken branch offered during REDIR
      cyc(1'b1, 5'b01101, 1'b1, 16'h0018, 8'h08, 1'b0);
      cyc(1'b1, 5'b01100, 1'b1, 16'h1000, 8'h10, 1'b0);
      idle(1'b0, 3);
      idle(1'b1, 3);
      // wrap in both directions
      cyc(1'b1, 5'b01110, 1'b1, 16'h0002, 8'hFC, 1'b1);
      idle(1'b1, 3);
      cyc(1'b1, 5'b01111, 1'b1, 16'hFFFE, 8'h04, 1'b1);
      idle(1'b1, 3);
      // random mix
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 3) != 0,
             $urandom_range(0, 1) ? {3'b011, 2'($urandom_range(0, 3))} : 5'($urandom),
             1'($urandom), 16'($urandom), 8'($urandom), $urandom_range(0, 2) != 0);
      idle(1'b1, 3);
      // asynchronous reset while a redirect is held
      cyc(1'b1, 5'b01100, 1'b1, 16'h0100, 8'h20, 1'b0);
      idle(1'b0, 2);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_valid", redirect_valid, 0);
      chk("async_rst_flush", {flush_ifid, flush_idex}, 0);
      chk("async_rst_pc", redirect_pc, 0);
      chk("async_rst_cnt", {br_cnt, taken_cnt}, 0);
      exp_q.delete();
      waiting = 0; flushing = 0; br_m = 0; tk_m = 0; last_pc_m = '0;
      idle(1'b1, 2);
      rst = 1'b1;
      idle(1'b1, 4);
      // saturate br_cnt with not-taken branches, then taken ones
      for (int i = 0; i < 65535; i++) cyc(1'b1, 5'b01110, 1'b0, 16'h0, 8'h0, 1'b1);
      cyc(1'b1, 5'b01100, 1'b1, 16'h1234, 8'h80, 1'b1);
      idle(1'b1, 3);
      cyc(1'b1, 5'b01101, 1'b1, 16'h2000, 8'h7F, 1'b1);
      idle(1'b1, 3);
      chk("sat_br_cnt", br_cnt, 16'hFFFF);
      chk("sat_taken_cnt", taken_cnt, 2);
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
